// File: rtl/nvram_upload.sv
// nvram_upload: serves core byte RAM to hps_io over the ioctl upload channel.
// Pauses the core, reads two bytes per request and returns them as one word.
module nvram_upload #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         RAM_AW       = 11,
  parameter int         RAM_LAT      = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [26:0]       ioctl_addr,
  output logic [15:0]       ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_RD_LO,
    S_WAIT_LO,
    S_RD_HI,
    S_WAIT_HI,
    S_OOR
  } state_e;

  state_e            state_q, state_d;
  logic              act_q, act_d;
  logic [RAM_AW-2:0] addr_q, addr_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       din_q, din_d;
  logic [1:0]        cnt_q, cnt_d;

  logic active;
  logic oor;
  logic lat_done;
  logic unused_addr0;

  assign active   = ioctl_upload &&
                    (ioctl_index == UPLOAD_INDEX);
  assign oor      = |ioctl_addr[26:RAM_AW];
  assign lat_done = (cnt_q == 2'(RAM_LAT - 1));
  assign unused_addr0 = ioctl_addr[0];

  // act_q resets high so an upload already running at reset release
  // must drop before a new session can start.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      act_q   <= 1'b1;
      addr_q  <= '0;
      lo_q    <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = active;
    addr_d  = addr_q;
    lo_d    = lo_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    if (!active) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!act_q) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (pause_ack) state_d = S_READY;
        end
        S_READY: begin
          if (ioctl_rd) begin
            addr_d  = ioctl_addr[RAM_AW-1:1];
            state_d = oor ? S_OOR : S_RD_LO;
          end else if (!pause_ack) begin
            state_d = S_PAUSE;
          end
        end
        // read strobes hold until the core is frozen again
        S_RD_LO: begin
          if (pause_ack) begin
            cnt_d   = '0;
            state_d = S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (lat_done) begin
            lo_d    = ram_dout;
            state_d = S_RD_HI;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_RD_HI: begin
          if (pause_ack) begin
            cnt_d   = '0;
            state_d = S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (lat_done) begin
            din_d   = {ram_dout, lo_q};
            state_d = pause_ack ? S_READY : S_PAUSE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_OOR: begin
          din_d   = 16'hFFFF;
          state_d = pause_ack ? S_READY : S_PAUSE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    pause_req  = busy;
    ioctl_wait = (state_q == S_PAUSE)   ||
                 (state_q == S_RD_LO)   ||
                 (state_q == S_WAIT_LO) ||
                 (state_q == S_RD_HI)   ||
                 (state_q == S_WAIT_HI) ||
                 (state_q == S_OOR);
    ram_rd     = ((state_q == S_RD_LO) ||
                  (state_q == S_RD_HI)) &&
                 pause_ack && active;
    ram_addr   = {addr_q, state_q == S_RD_HI};
    ioctl_din  = din_q;
  end

endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: two instances (RAM_LAT 1 and 3) against a byte RAM model.
// Words are scoreboarded when requested and checked when the wait drops.
module tb_nvram_upload;

  logic        clk;
  logic        rst_n;
  logic [7:0]  idx;
  logic        upl [2];
  logic        rdv [2];
  logic [26:0] adr [2];
  logic        ack [2];
  logic [15:0] din [2];
  logic        wt  [2];
  logic        preq[2];
  logic        rr  [2];
  logic        bsy [2];
  logic [10:0] ra  [2];
  logic [7:0]  rdo [2];

  logic [7:0]  mem [0:2047];
  logic [7:0]  p0  [3];
  logic [7:0]  p1  [3];

  int rdc[2];
  int wc[2];
  int viol;
  int n_cmp;
  int n_bad;

  logic [15:0] sb[$];

  typedef struct {
    logic [26:0] addr;
    logic [15:0] din;
    int          cyc;
    int          rds;
  } vec_t;

  vec_t vt[8];

  nvram_upload #(
    .UPLOAD_INDEX(8'd4), .RAM_AW(11), .RAM_LAT(1)
  ) u0 (
    .clk_sys(clk), .reset_n(rst_n),
    .ioctl_upload(upl[0]), .ioctl_index(idx),
    .ioctl_rd(rdv[0]), .ioctl_addr(adr[0]),
    .ioctl_din(din[0]), .ioctl_wait(wt[0]),
    .pause_req(preq[0]), .pause_ack(ack[0]),
    .ram_addr(ra[0]), .ram_rd(rr[0]),
    .ram_dout(rdo[0]), .busy(bsy[0])
  );

  nvram_upload #(
    .UPLOAD_INDEX(8'd4), .RAM_AW(11), .RAM_LAT(3)
  ) u1 (
    .clk_sys(clk), .reset_n(rst_n),
    .ioctl_upload(upl[1]), .ioctl_index(idx),
    .ioctl_rd(rdv[1]), .ioctl_addr(adr[1]),
    .ioctl_din(din[1]), .ioctl_wait(wt[1]),
    .pause_req(preq[1]), .pause_ack(ack[1]),
    .ram_addr(ra[1]), .ram_rd(rr[1]),
    .ram_dout(rdo[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // garbage when idle exposes a capture on the wrong cycle
  always @(posedge clk) begin
    p0[0] <= rr[0] ? mem[ra[0]] : 8'($urandom);
    p0[1] <= p0[0];
    p0[2] <= p0[1];
    p1[0] <= rr[1] ? mem[ra[1]] : 8'($urandom);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rdo[0] = p0[0];
  assign rdo[1] = p1[2];

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rr[s]) rdc[s]++;
      if (rr[s] && !ack[s]) viol++;
      if (wt[s]) wc[s]++;
    end
  end

  function automatic logic [15:0] model(logic [26:0] a);
    logic [10:0] lo;
    logic [10:0] hi;
    if (a[26:11] != 16'd0) return 16'hFFFF;
    lo = {a[10:1], 1'b0};
    hi = {a[10:1], 1'b1};
    return {mem[hi], mem[lo]};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic rd_word(input int s, input logic [26:0] a,
                         input bit spam, input logic [15:0] e,
                         output logic [15:0] d, output int cyc);
    @(posedge clk);
    #1;
    rdv[s] = 1'b1;
    adr[s] = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rdv[s] = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (wt[s] && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
      if (spam) begin
        rdv[s] = 1'($urandom_range(0, 1));
        adr[s] = 27'($urandom_range(0, 2047));
      end
      @(negedge clk);
    end
    rdv[s] = 1'b0;
    d = din[s];
  endtask

  task automatic start(input int s, input int dly);
    int n;
    @(posedge clk);
    #1 upl[s] = 1'b1;
    @(posedge clk);
    repeat (dly) @(posedge clk);
    #1 ack[s] = 1'b1;
    n = 0;
    @(negedge clk);
    while (wt[s] && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("session ready", {30'd0, wt[s], bsy[s]}, 32'd1);
  endtask

  task automatic stop(input int s);
    @(posedge clk);
    #1 upl[s] = 1'b0;
    @(posedge clk);
    #1 ack[s] = 1'b0;
  endtask

  task automatic run_p(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] e;
    logic [15:0] dprev;
    logic [26:0] a;
    int cyc;
    int w0;
    int r0;

    n_cmp = 0;
    n_bad = 0;
    viol  = 0;
    rst_n = 1'b0;
    idx   = 8'd4;
    for (int s = 0; s < 2; s++) begin
      upl[s] = 1'b0;
      rdv[s] = 1'b0;
      adr[s] = '0;
      ack[s] = 1'b0;
      rdc[s] = 0;
      wc[s]  = 0;
    end
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h34;
    mem[17] = 8'h12;

    vt[0] = '{27'h10, 16'h1234, 4, 2};
    vt[1] = '{27'h11, 16'h1234, 4, 2};
    vt[2] = '{27'h7FE, model(27'h7FE), 4, 2};
    vt[3] = '{27'h0, model(27'h0), 4, 2};
    vt[4] = '{27'h800, 16'hFFFF, 1, 0};
    vt[5] = '{27'h4000000, 16'hFFFF, 1, 0};
    vt[6] = '{27'h7FFFFFF, 16'hFFFF, 1, 0};
    vt[7] = '{27'h3A6, model(27'h3A6), 4, 2};

    run_p(3);
    chk("rst din", 32'(din[0]), 32'd0);
    chk("rst wait", 32'(wt[0]), 32'd0);
    chk("rst preq", 32'(preq[0]), 32'd0);
    chk("rst ram_rd", 32'(rr[0]), 32'd0);
    chk("rst ram_addr", 32'(ra[0]), 32'd0);
    chk("rst busy", 32'(bsy[0]), 32'd0);
    rst_n = 1'b1;

    idx = 8'd3;
    upl[0] = 1'b1;
    run_p(3);
    chk("wrong index preq", 32'(preq[0]), 32'd0);
    upl[0] = 1'b0;
    idx = 8'd4;
    run_p(1);

    w0 = wc[0];
    r0 = rdc[0];
    upl[0] = 1'b1;
    run_p(1);
    chk("pause preq", 32'(preq[0]), 32'd1);
    chk("pause wait", 32'(wt[0]), 32'd1);
    repeat (20) @(posedge clk);
    #1 ack[0] = 1'b1;
    run_p(2);
    chk("pause wait cycles", 32'(wc[0] - w0), 32'd21);
    chk("pause no ram_rd", 32'(rdc[0] - r0), 32'd0);
    chk("ready wait", 32'(wt[0]), 32'd0);
    chk("ready busy", 32'(bsy[0]), 32'd1);

    for (int i = 0; i < 8; i++) begin
      r0 = rdc[0];
      rd_word(0, vt[i].addr, 1'b0, vt[i].din, d, cyc);
      e = sb.pop_front();
      chk($sformatf("vec%0d din", i), 32'(d), 32'(e));
      chk($sformatf("vec%0d wait", i), 32'(cyc), 32'(vt[i].cyc));
      chk($sformatf("vec%0d ram_rd", i),
          32'(rdc[0] - r0), 32'(vt[i].rds));
    end

    run_p(1);
    ack[0] = 1'b0;
    run_p(1);
    chk("ack drop wait", 32'(wt[0]), 32'd1);
    chk("ack drop preq", 32'(preq[0]), 32'd1);
    ack[0] = 1'b1;
    run_p(1);
    chk("ack back wait", 32'(wt[0]), 32'd0);

    e = model(27'h20);
    rdv[0] = 1'b1;
    adr[0] = 27'h20;
    run_p(1);
    rdv[0] = 1'b0;
    run_p(3);
    ack[0] = 1'b0;
    run_p(1);
    chk("late ack din", 32'(din[0]), 32'(e));
    chk("late ack wait", 32'(wt[0]), 32'd1);
    ack[0] = 1'b1;
    run_p(1);
    chk("late ack resume", 32'(wt[0]), 32'd0);

    r0 = rdc[0];
    rdv[0] = 1'b1;
    adr[0] = 27'h30;
    upl[0] = 1'b0;
    run_p(1);
    rdv[0] = 1'b0;
    chk("rd+abort busy", 32'(bsy[0]), 32'd0);
    chk("rd+abort preq", 32'(preq[0]), 32'd0);
    run_p(1);
    chk("rd+abort ram_rd", 32'(rdc[0] - r0), 32'd0);
    ack[0] = 1'b0;

    start(0, 2);
    dprev = din[0];
    rdv[0] = 1'b1;
    adr[0] = 27'h40;
    run_p(1);
    rdv[0] = 1'b0;
    run_p(3);
    upl[0] = 1'b0;
    run_p(1);
    chk("abort preq", 32'(preq[0]), 32'd0);
    chk("abort wait", 32'(wt[0]), 32'd0);
    chk("abort busy", 32'(bsy[0]), 32'd0);
    chk("abort din held", 32'(din[0]), 32'(dprev));
    ack[0] = 1'b0;
    start(0, 1);
    rd_word(0, 27'h0, 1'b0, model(27'h0), d, cyc);
    e = sb.pop_front();
    chk("after abort din", 32'(d), 32'(e));

    rdv[0] = 1'b1;
    adr[0] = 27'h10;
    run_p(1);
    rdv[0] = 1'b0;
    run_p(1);
    rst_n = 1'b0;
    #1;
    chk("midrst din", 32'(din[0]), 32'd0);
    chk("midrst wait", 32'(wt[0]), 32'd0);
    chk("midrst preq", 32'(preq[0]), 32'd0);
    chk("midrst ram_rd", 32'(rr[0]), 32'd0);
    chk("midrst ram_addr", 32'(ra[0]), 32'd0);
    chk("midrst busy", 32'(bsy[0]), 32'd0);
    run_p(1);
    rst_n = 1'b1;
    run_p(4);
    chk("no restart preq", 32'(preq[0]), 32'd0);
    chk("no restart busy", 32'(bsy[0]), 32'd0);
    upl[0] = 1'b0;
    run_p(1);
    upl[0] = 1'b1;
    run_p(1);
    chk("restart preq", 32'(preq[0]), 32'd1);
    run_p(1);
    rd_word(0, 27'h10, 1'b0, 16'h1234, d, cyc);
    e = sb.pop_front();
    chk("restart din", 32'(d), 32'(e));
    stop(0);

    start(1, 3);
    for (int w = 0; w < 1024; w++) begin
      a = 27'(w * 2);
      rd_word(1, a, 1'b1, model(a), d, cyc);
      e = sb.pop_front();
      chk($sformatf("sweep %0h din", a), 32'(d), 32'(e));
      chk($sformatf("sweep %0h wait", a), 32'(cyc), 32'd8);
    end
    stop(1);

    run_p(2);
    chk("ram_rd without ack", 32'(viol), 32'd0);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
